// File: rtl/dsp_pkg.sv
// Shared helpers for the averager output chain: bit-drop width and parameter sanity.
package dsp_pkg;

  function automatic int unsigned drop_bits(input int unsigned iw, input int unsigned ow);
    return iw - ow;
  endfunction

  function automatic bit widths_ok(input int unsigned iw, input int unsigned ow,
                                   input int unsigned lgdecim);
    return (ow < iw) && (ow >= 2) && (lgdecim >= 1);
  endfunction

endpackage

// File: rtl/avgdecimate_if.sv
// Valid/ready output stream carrying the rounded, decimated sample.
interface avgdecimate_if #(
  parameter int unsigned OW = 12
) ();
  logic          valid;
  logic          ready;
  logic [OW-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/convround.sv
// Combinational convergent (round-half-to-even) narrowing from IW to OW bits,
// saturating at the most positive value.
module convround
  import dsp_pkg::*;
#(
  parameter int unsigned IW = 16,
  parameter int unsigned OW = 12
) (
  input  logic [IW-1:0] i_data,
  output logic [OW-1:0] o_round_c
);

  localparam int unsigned D = drop_bits(IW, OW);
  localparam logic [OW-1:0] MAX_POS = {1'b0, {(OW-1){1'b1}}};

  logic [OW-1:0] trunc;
  logic          sticky;
  logic          round_bit;

  assign trunc = i_data[IW-1:D];

  if (D >= 2) begin : g_sticky
    assign sticky = |i_data[D-2:0];
  end else begin : g_no_sticky
    assign sticky = 1'b0;
  end

  // Exact halves round toward the even neighbour, everything above half rounds up.
  assign round_bit = i_data[D-1] & (sticky | i_data[D]);

  always_comb begin
    o_round_c = trunc + OW'(round_bit);
    if (round_bit && (trunc == MAX_POS)) o_round_c = MAX_POS;
  end

endmodule

// File: rtl/avgdecimate.sv
// Decimating output stage: keeps one averaged sample per ratio, rounds it, and
// buffers it in a two-entry FIFO ahead of a valid/ready stream.
module avgdecimate
  import dsp_pkg::*;
#(
  parameter int unsigned IW      = 16,
  parameter int unsigned OW      = 12,
  parameter int unsigned LGDECIM = 8
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  input  logic               i_ce,
  input  logic [IW-1:0]      i_data,
  input  logic [LGDECIM-1:0] i_ratio,
  input  logic               i_clr_overflow,
  output logic               o_overflow,
  avgdecimate_if.master      out_if
);

  if (!widths_ok(IW, OW, LGDECIM)) begin : g_bad_widths
    $error("avgdecimate: requires OW < IW, OW >= 2 and LGDECIM >= 1");
  end

  logic [LGDECIM-1:0] cnt_q,   cnt_d;
  logic [OW-1:0]      head_q,  head_d;
  logic [OW-1:0]      spare_q, spare_d;
  logic [1:0]         occ_q,   occ_d;
  logic               valid_q, valid_d;
  logic               ovf_q,   ovf_d;

  logic [OW-1:0]      rounded_c;
  logic               sel_c;
  logic               pop_c;
  logic               push_c;
  logic [1:0]         occ_pop_c;

  convround #(.IW(IW), .OW(OW)) u_round (
    .i_data    (i_data),
    .o_round_c (rounded_c)
  );

  always_comb begin
    cnt_d     = cnt_q;
    head_d    = head_q;
    spare_d   = spare_q;
    occ_d     = occ_q;
    valid_d   = valid_q;
    ovf_d     = ovf_q;
    sel_c     = 1'b0;
    pop_c     = 1'b0;
    push_c    = 1'b0;
    occ_pop_c = occ_q;

    // Ratio is only looked at when a period ends; 0 behaves as 1.
    sel_c = i_ce && (cnt_q == '0);
    if (i_ce) begin
      if (sel_c) cnt_d = (i_ratio == '0) ? '0 : i_ratio - LGDECIM'(1);
      else       cnt_d = cnt_q - LGDECIM'(1);
    end

    // Pop first so a push into a full buffer can reuse the slot freed this cycle.
    pop_c     = valid_q && out_if.ready;
    occ_pop_c = occ_q - 2'(pop_c);
    if (pop_c && (occ_q == 2'd2)) head_d = spare_q;

    push_c = sel_c && (occ_pop_c != 2'd2);
    if (push_c) begin
      if (occ_pop_c == 2'd0) head_d  = rounded_c;
      else                   spare_d = rounded_c;
    end

    occ_d   = occ_pop_c + 2'(push_c);
    valid_d = (occ_d != 2'd0);

    if (sel_c && !push_c)     ovf_d = 1'b1;
    else if (i_clr_overflow)  ovf_d = 1'b0;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      cnt_q   <= '0;
      head_q  <= '0;
      spare_q <= '0;
      occ_q   <= 2'd0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      head_q  <= head_d;
      spare_q <= spare_d;
      occ_q   <= occ_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
    end
  end

  assign out_if.valid = valid_q;
  assign out_if.data  = head_q;
  assign o_overflow   = ovf_q;

endmodule

// File: tb/tb_avgdecimate.sv
// Scoreboard bench for avgdecimate: a reference model queues expected outputs,
// a negedge monitor compares the DUT stream, flag and data against them.
module tb_avgdecimate;

  localparam int unsigned IW      = 16;
  localparam int unsigned OW      = 12;
  localparam int unsigned LGDECIM = 8;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               i_ce = 1'b0;
  logic [IW-1:0]      i_data = '0;
  logic [LGDECIM-1:0] i_ratio = '0;
  logic               i_clr_overflow = 1'b0;
  logic               o_overflow;

  avgdecimate_if #(.OW(OW)) out_if ();

  avgdecimate #(.IW(IW), .OW(OW), .LGDECIM(LGDECIM)) dut (
    .i_clk          (clk),
    .i_reset_n      (rst_n),
    .i_ce           (i_ce),
    .i_data         (i_data),
    .i_ratio        (i_ratio),
    .i_clr_overflow (i_clr_overflow),
    .o_overflow     (o_overflow),
    .out_if         (out_if)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [OW-1:0] expq[$];
  logic          exp_ovf = 1'b0;
  int            ce_idx = 0;
  int            next_sel = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Round-half-to-even of x / 2^(IW-OW) using plain integer arithmetic.
  function automatic logic [OW-1:0] ref_round(input logic [IW-1:0] x);
    int v, step, rem, q;
    step = 1 << (IW - OW);
    v    = int'($signed(x));
    rem  = v & (step - 1);
    q    = (v - rem) / step;
    if (rem > step / 2 || (rem == step / 2 && (q % 2) != 0)) q++;
    if (q > (1 << (OW - 1)) - 1) q = (1 << (OW - 1)) - 1;
    return OW'(q);
  endfunction

  // Reference model: selects sample indices 0, r0, r0+r1, ... and holds at most two.
  always @(posedge clk or negedge rst_n) begin
    logic drop;
    if (!rst_n) begin
      expq.delete();
      exp_ovf  = 1'b0;
      ce_idx   = 0;
      next_sel = 0;
    end else begin
      drop = 1'b0;
      if (i_ce) begin
        if (ce_idx == next_sel) begin
          next_sel = ce_idx + ((i_ratio == 0) ? 1 : int'(i_ratio));
          if (expq.size() < 2) expq.push_back(ref_round(i_data));
          else drop = 1'b1;
        end
        ce_idx++;
      end
      if (drop) exp_ovf = 1'b1;
      else if (i_clr_overflow) exp_ovf = 1'b0;
    end
  end

  // Monitor: the head entry is consumed when the model holds data and ready is high.
  always @(negedge clk) begin
    chk("valid", 32'(out_if.valid), 32'(expq.size() != 0));
    chk("overflow", 32'(o_overflow), 32'(exp_ovf));
    if (expq.size() != 0) begin
      chk("data", 32'(out_if.data), 32'(expq[0]));
      if (out_if.ready) void'(expq.pop_front());
    end
  end

  task automatic step(input logic ce, input logic [IW-1:0] d, input logic [LGDECIM-1:0] r,
                      input logic rdy, input logic clr);
    @(posedge clk);
    #1;
    i_ce           = ce;
    i_data         = d;
    i_ratio        = r;
    out_if.ready   = rdy;
    i_clr_overflow = clr;
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) step(1'b0, '0, 8'd1, rdy, 1'b0);
  endtask

  logic [IW-1:0] edge_vals [8];
  logic [IW-1:0] rnd_vals  [6];

  initial begin
    out_if.ready = 1'b0;
    edge_vals = '{16'h0018, 16'h0008, 16'h0009, 16'hFFF8, 16'h7FF8, 16'h8000, 16'h7FFF, 16'hFFFF};
    rnd_vals  = '{16'h0018, 16'h0008, 16'h0009, 16'hFFF8, 16'h7FF8, 16'h8000};

    idle(3, 1'b0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Ratio 4 from reset: samples 0, 4, 8 come out as 0x001, 0x005, 0x009.
    for (int i = 0; i < 12; i++) step(1'b1, IW'((i + 1) * 16), 8'd4, 1'b1, 1'b0);
    idle(4, 1'b1);

    // Rounding corners at ratio 1.
    for (int i = 0; i < 6; i++) step(1'b1, rnd_vals[i], 8'd1, 1'b1, 1'b0);
    idle(3, 1'b1);

    // Backpressure: A and B held, C dropped, then drain and clear the flag.
    step(1'b1, 16'h1230, 8'd1, 1'b0, 1'b0);
    step(1'b1, 16'h4560, 8'd1, 1'b0, 1'b0);
    step(1'b1, 16'h7890, 8'd1, 1'b0, 1'b0);
    idle(3, 1'b0);
    idle(3, 1'b1);
    step(1'b0, '0, 8'd1, 1'b1, 1'b1);
    idle(2, 1'b1);

    // Full buffer receiving a push on the same cycle as a pop.
    step(1'b1, 16'h0100, 8'd1, 1'b0, 1'b0);
    step(1'b1, 16'h0200, 8'd1, 1'b0, 1'b0);
    step(1'b1, 16'h0300, 8'd1, 1'b1, 1'b0);
    step(1'b1, 16'h0400, 8'd1, 1'b1, 1'b0);
    idle(4, 1'b1);

    // Ratio 0 acts as 1, then a 3 -> 5 change inside a period.
    for (int i = 0; i < 5; i++) step(1'b1, IW'(16'h0040 * (i + 1)), 8'd0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, IW'(16'h0100 + 16 * i), 8'd3, 1'b1, 1'b0);
    for (int i = 0; i < 16; i++) step(1'b1, IW'(16'h0200 + 16 * i), 8'd5, 1'b1, 1'b0);
    idle(3, 1'b1);

    // Asynchronous reset with two entries held and the counter mid-period.
    for (int i = 0; i < 5; i++) step(1'b1, IW'(16'h0500 + 16 * i), 8'd3, 1'b0, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("valid_async_reset", 32'(out_if.valid), 32'd0);
    chk("data_async_reset", 32'(out_if.data), 32'd0);
    idle(2, 1'b1);
    @(posedge clk); #1 rst_n = 1'b1;
    step(1'b1, 16'h0ABC, 8'd7, 1'b1, 1'b0);
    step(1'b0, '0, 8'd7, 1'b1, 1'b0);
    chk("first_after_reset", 32'(out_if.data), 32'(12'h0AC));
    idle(3, 1'b1);

    // Randomized traffic with occasional rounding corners and flag clears.
    for (int i = 0; i < 1500; i++) begin
      logic [IW-1:0] d;
      d = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 7)] : IW'($urandom);
      step(1'(($urandom_range(0, 3) != 0)), d, LGDECIM'($urandom_range(0, 4)),
           1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 15) == 0));
    end
    idle(6, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
